// File: rtl/slowmem_if.sv
// Request/response bundle for the pipelined slow memory model.
interface slowmem_if #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 16
);
  logic              strobe;
  logic              rnotw;
  logic [AWIDTH-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic              busy;
  logic              mfc;
  logic [WIDTH-1:0]  rdata;

  modport master (
    output strobe, rnotw, addr, wdata,
    input  busy, mfc, rdata
  );

  modport slave (
    input  strobe, rnotw, addr, wdata,
    output busy, mfc, rdata
  );
endinterface

// File: rtl/slowmem_pipe.sv
// Pipelined slow memory: up to DEPTH in-order reads, each done DELAY cycles later.
// Define SLOWMEM_FWD_EN to forward a same-cycle write to the completing read.
module slowmem_pipe #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 16,
  parameter int DELAY  = 4,
  parameter int DEPTH  = 4
) (
  input logic       clk,
  input logic       reset,
  slowmem_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem [0:(1<<AWIDTH)-1];
  logic [AWIDTH-1:0] qaddr [0:DEPTH-1];
  logic [7:0]        cd [0:DEPTH-1];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic wr;
  logic accept;
  logic done;
  logic fwd;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign bus.busy = (count == CW'(DEPTH));
  assign wr       = bus.strobe && !bus.rnotw && !reset;
  assign accept   = bus.strobe && bus.rnotw && !bus.busy && !reset;
  assign done     = (count != '0) && (cd[head] == 8'd1);

`ifdef SLOWMEM_FWD_EN
  assign fwd = wr && (bus.addr == qaddr[head]);
`else
  assign fwd = 1'b0;
`endif

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr)
      mem[bus.addr] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      bus.mfc   <= 1'b0;
      bus.rdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cd[i]    <= '0;
        qaddr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (cd[i] > 8'd1)
          cd[i] <= cd[i] - 8'd1;
      if (accept) begin
        qaddr[tail] <= bus.addr;
        cd[tail]    <= 8'(DELAY);
        tail        <= nxt(tail);
      end
      if (done) begin
        bus.mfc   <= 1'b1;
        bus.rdata <= fwd ? bus.wdata : mem[qaddr[head]];
        head      <= nxt(head);
      end else begin
        bus.mfc   <= 1'b0;
        bus.rdata <= '0;
      end
      unique case ({accept, done})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (DEPTH >= 1 && DELAY >= 1)
      else $error("slowmem_pipe: DEPTH and DELAY must be >= 1");
  end
`endif
endmodule

// File: tb/tb_slowmem_pipe.sv
// Scoreboard bench for slowmem_pipe: DUT a (DEPTH=4) and DUT b (DEPTH=2).
module tb_slowmem_pipe;
  localparam int DLY = 4;

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slowmem_if #(.WIDTH(16), .AWIDTH(16)) sa ();
  slowmem_if #(.WIDTH(16), .AWIDTH(16)) sb ();

  slowmem_pipe #(.WIDTH(16), .AWIDTH(16), .DELAY(DLY), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .bus(sa.slave)
  );
  slowmem_pipe #(.WIDTH(16), .AWIDTH(16), .DELAY(DLY), .DEPTH(2)) u_b (
    .clk(clk), .reset(reset), .bus(sb.slave)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every mfc must match the head of its scoreboard, on the right cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sa.mfc) begin
      if (qa.size() == 0) chk("a_spurious_mfc", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_mfc_cycle", cyc, e.cyc);
        chk("a_rdata", int'(sa.rdata), int'(e.d));
      end
    end else chk("a_idle_rdata", int'(sa.rdata), 0);
    if (sb.mfc) begin
      if (qb.size() == 0) chk("b_spurious_mfc", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_mfc_cycle", cyc, e.cyc);
        chk("b_rdata", int'(sb.rdata), int'(e.d));
      end
    end else chk("b_idle_rdata", int'(sb.rdata), 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
    sa.strobe = 1'b0;
    sb.strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input bit b, input logic [15:0] a, input logic [15:0] d);
    if (b) begin
      sb.strobe = 1; sb.rnotw = 0; sb.addr = a; sb.wdata = d;
    end else begin
      sa.strobe = 1; sa.rnotw = 0; sa.addr = a; sa.wdata = d;
    end
    step();
  endtask

  task automatic rd(input bit b, input logic [15:0] a,
                    input logic [15:0] d, input bit acc);
    exp_t e;
    e.cyc = cyc + 1 + DLY;
    e.d   = d;
    if (b) begin
      sb.strobe = 1; sb.rnotw = 1; sb.addr = a;
      chk("b_busy", int'(sb.busy), int'(!acc));
      if (acc) qb.push_back(e);
    end else begin
      sa.strobe = 1; sa.rnotw = 1; sa.addr = a;
      chk("a_busy", int'(sa.busy), int'(!acc));
      if (acc) qa.push_back(e);
    end
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mfc", int'(sa.mfc), 0);
    chk("rst_rdata", int'(sa.rdata), 0);
    chk("rst_busy", int'(sa.busy), 0);
  endtask

  initial begin
    logic [15:0] fwd_exp;
`ifdef SLOWMEM_FWD_EN
    fwd_exp = 16'h2222;
`else
    fwd_exp = 16'h1111;
`endif
    sa.strobe = 0; sa.rnotw = 0; sa.addr = '0; sa.wdata = '0;
    sb.strobe = 0; sb.rnotw = 0; sb.addr = '0; sb.wdata = '0;
    step();
    do_reset();

    wr(0, 16'h0010, 16'hBEEF);
    for (int i = 1; i <= 4; i++) wr(0, 16'(i), 16'(16'h1000 + i));
    wr(0, 16'h0030, 16'h1111);
    for (int i = 1; i <= 5; i++) wr(1, 16'(16'h40 + i), 16'(16'h4000 + i));
    idle(1);

    // Single read latency
    rd(0, 16'h0010, 16'hBEEF, 1);
    idle(6);

    // Four back-to-back reads fill the queue; fifth refused
    for (int i = 1; i <= 4; i++) rd(0, 16'(i), 16'(16'h1000 + i), 1);
    rd(0, 16'h0005, 16'h0000, 0);
    idle(6);

    // Write during flight is visible
    rd(0, 16'h0020, 16'h5555, 1);
    idle(1);
    wr(0, 16'h0020, 16'h5555);
    idle(5);

    // Write lands in the completion cycle
    rd(0, 16'h0030, fwd_exp, 1);
    idle(3);
    wr(0, 16'h0030, 16'h2222);
    idle(2);
    rd(0, 16'h0030, 16'h2222, 1);
    idle(6);

    // Reset discards pending reads
    rd(0, 16'h0001, 16'h0, 1'b1);
    void'(qa.pop_back());
    rd(0, 16'h0002, 16'h0, 1'b1);
    void'(qa.pop_back());
    rd(0, 16'h0003, 16'h0, 1'b1);
    void'(qa.pop_back());
    do_reset();
    idle(1);
    rd(0, 16'h0004, 16'h1004, 1);
    idle(6);

    // DEPTH=2 instance: full-at-start refusal even when head pops
    rd(1, 16'h0041, 16'h4001, 1);
    rd(1, 16'h0042, 16'h4002, 1);
    rd(1, 16'h0043, 16'h0000, 0);
    idle(1);
    rd(1, 16'h0044, 16'h0000, 0);
    rd(1, 16'h0045, 16'h4005, 1);
    idle(8);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
